// File: rtl/ks8_rr_sched.sv
// ---------------------------------------------------------------------------
// ks8_rr_sched
//
// Purpose:
//   Four requesters share one 8-bit Kogge-Stone adder. A round-robin arbiter
//   picks one valid requester per cycle and adds its operands. The 9-bit sum
//   goes into a single result slot. The slot is either EMPTY or FULL.
//   The slot accepts a new sum when it is empty, or when it is full and the
//   consumer takes the current result in the same cycle. This gives
//   back-to-back throughput.
//
// Optional feature:
//   KS8_SCHED_STATS_EN  - when defined, ops_count counts grants and saturates
//                         at all-ones. When undefined, ops_count is tied to 0
//                         and no counter flops exist.
//
// Ports:
//   clk        in   1      sole clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   flush      in   1      synchronous clear of result slot and pointer
//   req_valid  in   4      per-requester operand valid
//   req_a      in   32     operand A, requester i on [8i+7:8i]
//   req_b      in   32     operand B, same packing
//   req_ready  out  4      one-hot grant (combinational)
//   res_valid  out  1      result slot holds a sum
//   res_sum    out  9      registered sum, carry in bit 8
//   res_id     out  2      requester that owns res_sum
//   res_ready  in   1      consumer accepts result
//   ops_count  out  CNT_W  accepted-operation count
// ---------------------------------------------------------------------------
module ks8_rr_sched #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [3:0]       req_valid,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic [3:0]       req_ready,
    output logic             res_valid,
    output logic [8:0]       res_sum,
    output logic [1:0]       res_id,
    input  logic             res_ready,
    output logic [CNT_W-1:0] ops_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t state_reg, state_next;
    logic [1:0]  ptr_reg;
    logic [8:0]  sum_reg;
    logic [1:0]  id_reg;

    logic        slot_free;
    logic        grant_any;
    logic [1:0]  grant_idx;
    logic        grant_en;
    logic [7:0]  a_sel, b_sel;
    logic [8:0]  sum_ks;

    // -----------------------------------------------------------------------
    // Round-robin arbitration. The scan runs from the highest offset down to
    // offset 0. The last hit wins, so the first valid requester at or after
    // ptr_reg is chosen.
    // -----------------------------------------------------------------------
    always_comb begin
        grant_any = 1'b0;
        grant_idx = ptr_reg;
        for (int k = 3; k >= 0; k--) begin
            if (req_valid[ptr_reg + 2'(k)]) begin
                grant_any = 1'b1;
                grant_idx = ptr_reg + 2'(k);
            end
        end
    end

    assign slot_free = (state_reg == EMPTY) || res_ready;
    // rst is gated in explicitly. Otherwise the EMPTY slot would advertise a
    // grant while reset is held.
    assign grant_en  = grant_any && slot_free && !flush && !rst;
    assign req_ready = grant_en ? (4'b0001 << grant_idx) : 4'b0000;

    // Only the granted requester's operands reach the adder.
    assign a_sel = req_a[8*grant_idx +: 8];
    assign b_sel = req_b[8*grant_idx +: 8];

    // -----------------------------------------------------------------------
    // Kogge-Stone prefix adder. The prefix levels use spans of 1, 2 and 4.
    // g_l3[i] is the carry out of bit i. The carry-in is zero. Group
    // propagate terms are kept only where a later level consumes them.
    // -----------------------------------------------------------------------
    logic [7:0] g_l0, p_l0, g_l1, p_l1, g_l2, g_l3;
    logic [7:4] p_l2;

    assign g_l0 = a_sel & b_sel;
    assign p_l0 = a_sel ^ b_sel;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lvl1
            if (gi >= 1) begin : g_comb
                assign g_l1[gi] = g_l0[gi] | (p_l0[gi] & g_l0[gi-1]);
                assign p_l1[gi] = p_l0[gi] & p_l0[gi-1];
            end else begin : g_pass
                assign g_l1[gi] = g_l0[gi];
                assign p_l1[gi] = p_l0[gi];
            end
        end

        for (genvar gi = 0; gi < 8; gi++) begin : g_lvl2
            if (gi >= 2) begin : g_comb
                assign g_l2[gi] = g_l1[gi] | (p_l1[gi] & g_l1[gi-2]);
            end else begin : g_pass
                assign g_l2[gi] = g_l1[gi];
            end
            if (gi >= 4) begin : g_prop
                assign p_l2[gi] = p_l1[gi] & p_l1[gi-2];
            end
        end

        for (genvar gi = 0; gi < 8; gi++) begin : g_lvl3
            if (gi >= 4) begin : g_comb
                assign g_l3[gi] = g_l2[gi] | (p_l2[gi] & g_l2[gi-4]);
            end else begin : g_pass
                assign g_l3[gi] = g_l2[gi];
            end
        end
    endgenerate

    assign sum_ks = {g_l3[7], p_l0 ^ {g_l3[6:0], 1'b0}};

    // -----------------------------------------------------------------------
    // Slot FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = EMPTY;
        end else if (grant_en) begin
            state_next = FULL;
        end else if (state_reg == FULL && res_ready) begin
            state_next = EMPTY;
        end
    end

    // -----------------------------------------------------------------------
    // Result slot data and round-robin pointer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg <= 9'd0;
            id_reg  <= 2'd0;
            ptr_reg <= 2'd0;
        end else if (flush) begin
            sum_reg <= 9'd0;
            id_reg  <= 2'd0;
            ptr_reg <= 2'd0;
        end else if (grant_en) begin
            sum_reg <= sum_ks;
            id_reg  <= grant_idx;
            ptr_reg <= grant_idx + 2'd1;
        end
    end

    assign res_valid = (state_reg == FULL);
    assign res_sum   = sum_reg;
    assign res_id    = id_reg;

    // -----------------------------------------------------------------------
    // Optional grant counter. Flush does not affect it.
    // -----------------------------------------------------------------------
`ifdef KS8_SCHED_STATS_EN
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (grant_en && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign ops_count = cnt_reg;
`else
    assign ops_count = '0;
`endif

endmodule

// File: tb/tb_ks8_rr_sched.sv
module tb_ks8_rr_sched;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [3:0]       req_valid;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [3:0]       req_ready;
    logic             res_valid;
    logic [8:0]       res_sum;
    logic [1:0]       res_id;
    logic             res_ready;
    logic [CNT_W-1:0] ops_count;

    ks8_rr_sched #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .res_ready (res_ready),
        .ops_count (ops_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [8:0] sum;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_res(input logic [1:0] id, input logic [8:0] sum);
        exp_t e;
        e.id  = id;
        e.sum = sum;
        exp_q.push_back(e);
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Operands 0x10*(i+1) and (i+1). The expected sum for requester i is 0x11*(i+1).
    task automatic load_pattern();
        for (int i = 0; i < 4; i++) begin
            set_op(i, 8'(16 * (i + 1)), 8'(i + 1));
        end
    endtask

    function automatic logic [8:0] pattern_sum(input int id);
        return 9'(17 * (id + 1));
    endfunction

    // Monitor: each cycle in which the consumer takes a result retires one entry.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got id=%0d sum=0x%0h, expected none", res_id, res_sum);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn id=%0d sum=0x%03h (expected id=%0d sum=0x%03h)", res_id, res_sum, e.id, e.sum);
                check("res_id", 32'(res_id), 32'(e.id));
                check("res_sum", 32'(res_sum), 32'(e.sum));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 4'b0000;
        req_a     = 32'd0;
        req_b     = 32'd0;
        res_ready = 1'b0;

        // Reset state
        #2;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_sum", 32'(res_sum), 32'd0);
        check("rst_ops_count", 32'(ops_count), 32'd0);
        req_valid = 4'b1111;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = 4'b0000;
        tick();
        tick();
        rst = 1'b0;

        // Single request: 0x12 + 0x34 = 0x046, latency one cycle
        set_op(0, 8'h12, 8'h34);
        req_valid = 4'b0001;
        res_ready = 1'b1;
        #1;
        check("single_req_ready", 32'(req_ready), 32'b0001);
        expect_res(2'd0, 9'h046);
        tick();
        check("single_latency", 32'(res_valid), 32'd1);
        req_valid = 4'b0000;
        tick();
        check("single_drain", 32'(res_valid), 32'd0);

        // Flush: no grant in the flush cycle, pointer returns to 0
        load_pattern();
        flush     = 1'b1;
        req_valid = 4'b1111;
        #1;
        check("flush_no_grant", 32'(req_ready), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_ptr0", 32'(req_ready), 32'b0001);
`ifdef KS8_SCHED_STATS_EN
        check("flush_keeps_count", 32'(ops_count), 32'd1);
`else
        check("flush_keeps_count", 32'(ops_count), 32'd0);
`endif

        // Fairness: ids 0,1,2,3,0 with all requesters held valid
        for (int k = 0; k < 5; k++) begin
            expect_res(2'(k % 4), pattern_sum(k % 4));
        end
        repeat (5) tick();
        req_valid = 4'b0000;
        tick();

        // Backpressure (pointer is 1). Requester 1 changes its operands while held.
        res_ready = 1'b0;
        set_op(1, 8'hAB, 8'h11);
        req_valid = 4'b0010;
        expect_res(2'd1, 9'h0BC);
        tick();
        set_op(1, 8'h05, 8'h06);
        for (int k = 0; k < 5; k++) begin
            check("bp_res_valid", 32'(res_valid), 32'd1);
            check("bp_res_sum", 32'(res_sum), 32'h0BC);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        expect_res(2'd1, 9'h00B);
        res_ready = 1'b1;
        #1;
        check("bp_release_grant", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0000;
        tick();

        // Carry (pointer is 2)
        req_valid = 4'b0100;
        set_op(2, 8'hFF, 8'h01);
        expect_res(2'd2, 9'h100);
        tick();
        set_op(2, 8'hFF, 8'hFF);
        expect_res(2'd2, 9'h1FE);
        tick();
        req_valid = 4'b0000;
        tick();

        // Reset while FULL. The pointer would be 3 after this grant to 2.
        res_ready = 1'b0;
        set_op(2, 8'h07, 8'h08);
        req_valid = 4'b0100;
        tick();
        check("mid_full", 32'(res_valid), 32'd1);
`ifdef KS8_SCHED_STATS_EN
        check("count_before_rst", 32'(ops_count), 32'd11);
`else
        check("count_before_rst", 32'(ops_count), 32'd0);
`endif
        rst = 1'b1;
        #1;
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_res_sum", 32'(res_sum), 32'd0);
        check("mid_rst_res_id", 32'(res_id), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_ops_count", 32'(ops_count), 32'd0);
        #2;
        rst = 1'b0;
        req_valid = 4'b1010;
        set_op(1, 8'h20, 8'h02);
        set_op(3, 8'h99, 8'h99);
        res_ready = 1'b1;
        #1;
        check("post_rst_lowest", 32'(req_ready), 32'b0010);
        expect_res(2'd1, 9'h022);
        tick();
        req_valid = 4'b0000;
        tick();

        // Stats: 1 grant since reset plus 19 more (pointer starts at 2)
        load_pattern();
        req_valid = 4'b1111;
        for (int k = 0; k < 19; k++) begin
            expect_res(2'((2 + k) % 4), pattern_sum((2 + k) % 4));
        end
        repeat (19) tick();
        req_valid = 4'b0000;
        tick();
`ifdef KS8_SCHED_STATS_EN
        check("stats_saturate", 32'(ops_count), 32'd15);
`else
        check("stats_disabled", 32'(ops_count), 32'd0);
`endif
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
